// File: rtl/dma_wr_burst_ctrl.sv
// dma_wr_burst_ctrl: splits a decompressed page into AXI write bursts, gates
// beat flow so W never leads AW, generates wlast and tracks B responses.
// Optional build macro DMA_WR_STATS_EN adds burst and stall statistics ports.
module dma_wr_burst_ctrl #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned BURST_BEATS = 64,
  parameter int unsigned MAX_OUTST   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [31:0]       decompression_length,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  output logic              bresp_err,
  input  logic [1:0]        bresp
`ifdef DMA_WR_STATS_EN
  ,
  output logic [15:0]       stat_bursts,
  output logic [31:0]       stat_stall
`endif
);

  localparam int unsigned BEAT_W      = 26;
  localparam int unsigned LEN_W       = 8;
  localparam int unsigned OUT_W       = $clog2(MAX_OUTST + 1);
  localparam int unsigned LOG_BB      = $clog2(BURST_BEATS);
  localparam int unsigned BURST_BYTES = 64 * BURST_BEATS;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(BURST_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_e;

  state_e              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [LEN_W-1:0]    awlen_q, awlen_d;
  logic [BEAT_W-1:0]   aw_left_q, aw_left_d;
  logic [BEAT_W-1:0]   w_left_q, w_left_d;
  logic [LEN_W-1:0]    last_len_q, last_len_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0]    credit_q, credit_d;
  logic [OUT_W-1:0]    outst_q, outst_d;
  logic                bresp_err_q, bresp_err_d;

  logic [BEAT_W-1:0]   total_beats, burst_rem, total_bursts;
  logic [LEN_W-1:0]    first_last_len, cur_len;
  logic                run, aw_fire, w_credit, w_fire, b_fire;

  // Page geometry derived from the requested length
  assign total_beats    = BEAT_W'(decompression_length[31:6]) + BEAT_W'(|decompression_length[5:0]);
  assign burst_rem      = total_beats & BEAT_W'(BURST_BEATS - 1);
  assign total_bursts   = (total_beats >> LOG_BB) + BEAT_W'(burst_rem != '0);
  assign first_last_len = (burst_rem == '0) ? FULL_LEN : LEN_W'(burst_rem - BEAT_W'(1));

  // Handshake decode; W is released only against an accepted (or accepting) AW
  assign run      = (state_q == S_RUN);
  assign aw_fire  = awvalid_q & awready;
  assign w_credit = run & ((credit_q != '0) | aw_fire);
  assign cur_len  = (w_left_q == BEAT_W'(1)) ? last_len_q : FULL_LEN;
  assign wvalid   = in_valid & w_credit;
  assign in_ready = wready & w_credit;
  assign wlast    = w_credit & (beat_cnt_q == cur_len);
  assign w_fire   = in_valid & wready & w_credit;
  assign b_fire   = bvalid & bready;

  assign busy      = (state_q != S_IDLE);
  assign bready    = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign awlen     = awlen_q;
  assign bresp_err = bresp_err_q;

  // Next-state, AW issue, W beat tracking and response bookkeeping
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    aw_left_d   = aw_left_q;
    w_left_d    = w_left_q;
    last_len_d  = last_len_q;
    beat_cnt_d  = beat_cnt_q;
    credit_d    = credit_q + OUT_W'(aw_fire) - OUT_W'(w_fire & wlast);
    outst_d     = outst_q + OUT_W'(aw_fire) - OUT_W'(b_fire);
    bresp_err_d = bresp_err_q | (b_fire & (bresp != 2'b00));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bresp_err_d = 1'b0;
          beat_cnt_d  = '0;
          credit_d    = '0;
          outst_d     = '0;
          awaddr_d    = dest_addr & ~ADDR_W'(6'h3F);
          aw_left_d   = total_bursts;
          w_left_d    = total_bursts;
          last_len_d  = first_last_len;
          awlen_d     = (total_bursts == BEAT_W'(1)) ? first_last_len : FULL_LEN;
          if (total_beats == '0) begin
            state_d = S_FIN;
          end else begin
            state_d   = S_RUN;
            awvalid_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (aw_fire) begin
          aw_left_d = aw_left_q - BEAT_W'(1);
          awaddr_d  = awaddr_q + ADDR_W'(BURST_BYTES);
          awlen_d   = (aw_left_q == BEAT_W'(2)) ? last_len_q : FULL_LEN;
          awvalid_d = (aw_left_q > BEAT_W'(1)) && (outst_d < OUT_W'(MAX_OUTST));
        end else if (!awvalid_q && (aw_left_q != '0) && (outst_q < OUT_W'(MAX_OUTST))) begin
          awvalid_d = 1'b1;
        end
        if (w_fire) begin
          if (wlast) begin
            beat_cnt_d = '0;
            w_left_d   = w_left_q - BEAT_W'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
        if ((aw_left_d == '0) && (w_left_d == '0)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outst_d == '0) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      aw_left_q   <= '0;
      w_left_q    <= '0;
      last_len_q  <= '0;
      beat_cnt_q  <= '0;
      credit_q    <= '0;
      outst_q     <= '0;
      bresp_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      aw_left_q   <= aw_left_d;
      w_left_q    <= w_left_d;
      last_len_q  <= last_len_d;
      beat_cnt_q  <= beat_cnt_d;
      credit_q    <= credit_d;
      outst_q     <= outst_d;
      bresp_err_q <= bresp_err_d;
    end
  end

`ifdef DMA_WR_STATS_EN
  logic [15:0] stat_bursts_q, stat_bursts_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  assign stat_bursts = stat_bursts_q;
  assign stat_stall  = stat_stall_q;

  // Saturating burst and stall counters, cleared when a page is accepted
  always_comb begin
    stat_bursts_d = stat_bursts_q;
    stat_stall_d  = stat_stall_q;
    if ((state_q == S_IDLE) && start) begin
      stat_bursts_d = '0;
      stat_stall_d  = '0;
    end else begin
      if (aw_fire && (stat_bursts_q != '1)) stat_bursts_d = stat_bursts_q + 16'd1;
      if (run && in_valid && !in_ready && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bursts_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_bursts_q <= stat_bursts_d;
      stat_stall_q  <= stat_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_dma_wr_burst_ctrl.sv
// Directed bench for dma_wr_burst_ctrl with an AXI-side monitor and B responder.
module tb_dma_wr_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] dest_addr;
  logic [31:0] decompression_length;
  logic        busy, done, in_valid, in_ready;
  logic        awvalid, awready;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wready, wlast;
  logic        bvalid, bready, bresp_err;
  logic [1:0]  bresp;
`ifdef DMA_WR_STATS_EN
  logic [15:0] stat_bursts;
  logic [31:0] stat_stall;
`endif

  always #5 clk = ~clk;

  dma_wr_burst_ctrl #(.ADDR_W(64), .BURST_BEATS(64), .MAX_OUTST(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dest_addr(dest_addr),
    .decompression_length(decompression_length), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .awvalid(awvalid), .awready(awready),
    .awaddr(awaddr), .awlen(awlen), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp_err(bresp_err), .bresp(bresp)
`ifdef DMA_WR_STATS_EN
    , .stat_bursts(stat_bursts), .stat_stall(stat_stall)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc, aw_n, w_n, b_n, wlast_n, done_n, done_cyc, last_b_cyc, b_pending, outst_max, b_err_idx;
  bit b_auto;
  logic err_at_done;
  logic [63:0] aw_addr_log [0:31];
  logic [7:0]  aw_len_log  [0:31];
  int          wlast_at    [0:31];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    aw_n = 0; w_n = 0; b_n = 0; wlast_n = 0; done_n = 0; done_cyc = -1;
    last_b_cyc = -100; b_pending = 0; outst_max = 0; err_at_done = 1'bx;
    for (int i = 0; i < 32; i++) begin
      aw_addr_log[i] = '0; aw_len_log[i] = '0; wlast_at[i] = 0;
    end
  endtask

  // One clock: drive B, observe handshakes mid-cycle, advance to just after the next edge
  task automatic step();
    bvalid = b_auto && (b_pending > 0);
    bresp  = (bvalid && (b_n == b_err_idx)) ? 2'b10 : 2'b00;
    #1;
    if (awvalid && awready) begin
      if (aw_n < 32) begin aw_addr_log[aw_n] = awaddr; aw_len_log[aw_n] = awlen; end
      aw_n++;
    end
    if (wvalid && wready) begin
      w_n++;
      if (wlast) begin
        if (wlast_n < 32) wlast_at[wlast_n] = w_n;
        wlast_n++;
        b_pending++;
      end
    end
    if (bvalid && bready) begin b_n++; b_pending--; last_b_cyc = cyc; end
    if ((aw_n - b_n) > outst_max) outst_max = aw_n - b_n;
    if (done) begin done_n++; done_cyc = cyc; err_at_done = bresp_err; end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic start_page(input logic [31:0] len, input logic [63:0] addr);
    decompression_length = len;
    dest_addr = addr;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0;
    n0 = done_n;
    for (int i = 0; i < budget && done_n == n0; i++) step();
    check(tag, 64'(done_n - n0), 64'd1);
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"},      64'(busy),      64'd0);
    check({pfx, "_done"},      64'(done),      64'd0);
    check({pfx, "_awvalid"},   64'(awvalid),   64'd0);
    check({pfx, "_awaddr"},    awaddr,         64'd0);
    check({pfx, "_awlen"},     64'(awlen),     64'd0);
    check({pfx, "_wvalid"},    64'(wvalid),    64'd0);
    check({pfx, "_in_ready"},  64'(in_ready),  64'd0);
    check({pfx, "_wlast"},     64'(wlast),     64'd0);
    check({pfx, "_bready"},    64'(bready),    64'd0);
    check({pfx, "_bresp_err"}, 64'(bresp_err), 64'd0);
  endtask

  initial begin
    int held_bad;
    rst_n = 1'b0; start = 1'b0; dest_addr = '0; decompression_length = '0;
    in_valid = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    b_auto = 1'b1; b_err_idx = -1; cyc = 0;
    mon_clear();
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single 4 KB burst
    mon_clear();
    start_page(32'd4096, 64'h1000);
    check("p1_awvalid_after_start", 64'(awvalid), 64'd1);
    check("p1_busy", 64'(busy), 64'd1);
    wait_done("p1_done", 400);
    check("p1_aw_count", 64'(aw_n), 64'd1);
    check("p1_awaddr", aw_addr_log[0], 64'h1000);
    check("p1_awlen", 64'(aw_len_log[0]), 64'd63);
    check("p1_beats", 64'(w_n), 64'd64);
    check("p1_wlast_count", 64'(wlast_n), 64'd1);
    check("p1_wlast_pos", 64'(wlast_at[0]), 64'd64);
    check("p1_done_after_b", 64'(done_cyc - last_b_cyc), 64'd1);
    check("p1_busy_after", 64'(busy), 64'd0);

    // 8257 bytes: 130 beats in bursts of 64, 64, 2
    mon_clear();
    start_page(32'd8257, 64'h40000);
    wait_done("p2_done", 600);
    check("p2_aw_count", 64'(aw_n), 64'd3);
    check("p2_awaddr0", aw_addr_log[0], 64'h40000);
    check("p2_awaddr1", aw_addr_log[1], 64'h41000);
    check("p2_awaddr2", aw_addr_log[2], 64'h42000);
    check("p2_awlen0", 64'(aw_len_log[0]), 64'd63);
    check("p2_awlen1", 64'(aw_len_log[1]), 64'd63);
    check("p2_awlen2", 64'(aw_len_log[2]), 64'd1);
    check("p2_beats", 64'(w_n), 64'd130);
    check("p2_wlast0", 64'(wlast_at[0]), 64'd64);
    check("p2_wlast1", 64'(wlast_at[1]), 64'd128);
    check("p2_wlast2", 64'(wlast_at[2]), 64'd130);

    // Zero-length page: straight to the done pulse, no traffic
    mon_clear();
    start_page(32'd0, 64'h5000);
    check("p3_busy", 64'(busy), 64'd1);
    check("p3_done", 64'(done), 64'd1);
    check("p3_awvalid", 64'(awvalid), 64'd0);
    step();
    check("p3_busy_after", 64'(busy), 64'd0);
    check("p3_done_after", 64'(done), 64'd0);
    check("p3_no_aw", 64'(aw_n), 64'd0);

    // AW back-pressure: no beat may leak ahead of the first address
    mon_clear();
    awready = 1'b0;
    start_page(32'd8192, 64'h8000);
    held_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready !== 1'b0 || wvalid !== 1'b0) held_bad++;
      step();
    end
    check("p4_w_held", 64'(held_bad), 64'd0);
    check("p4_no_beats", 64'(w_n), 64'd0);
    check("p4_awvalid_held", 64'(awvalid), 64'd1);
    check("p4_awaddr_stable", awaddr, 64'h8000);
    awready = 1'b1;
    wait_done("p4_done", 600);
    check("p4_aw_count", 64'(aw_n), 64'd2);
    check("p4_beats", 64'(w_n), 64'd128);

    // 64 KB with B withheld: outstanding limit of 4
    mon_clear();
    b_auto = 1'b0;
    start_page(32'd65536, 64'h100000);
    repeat (300) step();
    check("p5_aw_capped", 64'(aw_n), 64'd4);
    check("p5_beats_capped", 64'(w_n), 64'd256);
    check("p5_in_ready_stalled", 64'(in_ready), 64'd0);
    b_auto = 1'b1;
    step();
    b_auto = 1'b0;
    repeat (10) step();
    check("p5_one_b", 64'(b_n), 64'd1);
    check("p5_fifth_aw", 64'(aw_n), 64'd5);
    check("p5_fifth_addr", aw_addr_log[4], 64'h104000);
    b_auto = 1'b1;
    wait_done("p5_done", 3000);
    check("p5_aw_total", 64'(aw_n), 64'd16);
    check("p5_b_total", 64'(b_n), 64'd16);
    check("p5_outst_max", 64'(outst_max), 64'd4);
    check("p5_beats", 64'(w_n), 64'd1024);
    check("p5_wlast_count", 64'(wlast_n), 64'd16);

    // SLVERR on the second response: sticky until the next start
    mon_clear();
    b_err_idx = 1;
    start_page(32'd12288, 64'h200000);
    wait_done("p6_done", 600);
    check("p6_err_at_done", 64'(err_at_done), 64'd1);
    check("p6_err_sticky_idle", 64'(bresp_err), 64'd1);
    b_err_idx = -1;
    mon_clear();
    start_page(32'd64, 64'h300000);
    check("p6_err_cleared", 64'(bresp_err), 64'd0);
    wait_done("p7_done", 100);
    check("p7_one_beat_awlen", 64'(aw_len_log[0]), 64'd0);
    check("p7_wlast_pos", 64'(wlast_at[0]), 64'd1);
    check("p7_err_at_done", 64'(err_at_done), 64'd0);

    // Asynchronous reset in the middle of a page
    mon_clear();
    start_page(32'd4096, 64'h1000);
    repeat (10) step();
    check("p8_busy_mid", 64'(busy), 64'd1);
    check("p8_wvalid_mid", 64'(wvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("p8_async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
